// File: rtl/t01_uart_cmd_rx_if.sv
// ----------------------------------------------------------------------------
// t01_uart_cmd_rx_if
// Bundles the serial input line and all receiver outputs of t01_uart_cmd_rx.
//   rx                 : raw serial line, idle high (driven by the line side)
//   rx_byte[7:0]       : last correctly framed byte
//   rx_valid           : one-cycle pulse, rx_byte just updated
//   frame_err          : one-cycle pulse, stop bit sampled low
//   busy               : receiver not idle
//   cmd_left/right/rot_r/rot_l/speed/start : one-cycle command pulses
// master = line/host side, slave = receiver.
// ----------------------------------------------------------------------------
interface t01_uart_cmd_rx_if;
    logic       rx;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic       cmd_left;
    logic       cmd_right;
    logic       cmd_rot_r;
    logic       cmd_rot_l;
    logic       cmd_speed;
    logic       cmd_start;

    modport master (
        output rx,
        input  rx_byte, rx_valid, frame_err, busy,
        input  cmd_left, cmd_right, cmd_rot_r, cmd_rot_l, cmd_speed, cmd_start
    );

    modport slave (
        input  rx,
        output rx_byte, rx_valid, frame_err, busy,
        output cmd_left, cmd_right, cmd_rot_r, cmd_rot_l, cmd_speed, cmd_start
    );
endinterface

// File: rtl/t01_uart_cmd_rx.sv
// ----------------------------------------------------------------------------
// t01_uart_cmd_rx
// 8N1 UART receiver with ASCII command decode for the Tetris build.
//   clk   : system clock
//   nrst  : asynchronous active-low reset
//   bus   : t01_uart_cmd_rx_if.slave (rx in; byte, valid, frame_err, busy and
//           cmd_* pulses out)
// Command bytes: 'a' left, 'd' right, 'w' rotate right, 'q' rotate left,
// 's' speed, ' ' start. Any other byte yields rx_valid with no cmd pulse.
// ----------------------------------------------------------------------------
module t01_uart_cmd_rx #(
    parameter int unsigned CLKS_PER_BIT = 217,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic              clk,
    input  logic              nrst,
    t01_uart_cmd_rx_if.slave  bus
);
    localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e        state_q, state_d;
    logic          rx_meta_q, rxs_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    // {start, speed, rot_l, rot_r, right, left}
    logic [5:0]    cmd_q, cmd_d;

    function automatic logic [5:0] decode(input logic [7:0] b);
        logic [5:0] c;
        c = '0;
        case (b)
            8'h61:   c = 6'b000001;
            8'h64:   c = 6'b000010;
            8'h77:   c = 6'b000100;
            8'h71:   c = 6'b001000;
            8'h73:   c = 6'b010000;
            8'h20:   c = 6'b100000;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            cmd_q   <= cmd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        cmd_d   = '0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                idx_d = '0;
                if (cnt_q == CNT_HALF) state_d = rxs_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                // Sampling points are one full bit apart, starting one bit
                // after mid-start, so each lands mid-bit.
                if (cnt_q == CNT_LAST) begin
                    shift_d[idx_q] = rxs_q;
                    cnt_d          = '0;
                    if (idx_q == 3'd7) state_d = S_STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_STOP: begin
                // Returning to IDLE at mid-stop leaves half a bit of margin
                // to catch a start bit that follows immediately.
                if (cnt_q == CNT_LAST) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                        cmd_d   = decode(shift_q);
                    end else begin
                        state_d = S_WAIT_HIGH;
                        ferr_d  = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Every state entry restarts the baud counter.
        if (state_d != state_q) cnt_d = '0;
    end

    assign bus.rx_byte   = byte_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.cmd_left  = cmd_q[0];
    assign bus.cmd_right = cmd_q[1];
    assign bus.cmd_rot_r = cmd_q[2];
    assign bus.cmd_rot_l = cmd_q[3];
    assign bus.cmd_speed = cmd_q[4];
    assign bus.cmd_start = cmd_q[5];
endmodule

// File: tb/tb_t01_uart_cmd_rx.sv
// ----------------------------------------------------------------------------
// tb_t01_uart_cmd_rx
// Self-checking bench for t01_uart_cmd_rx at 16 clocks per bit. Frames are
// driven as timed waveforms on rx; a queue of expected events (good byte or
// framing error) is matched against every rx_valid / frame_err pulse.
// ----------------------------------------------------------------------------
module tb_t01_uart_cmd_rx;
    localparam int CPB   = 16;
    localparam int HALFP = 50;            // half clock period
    localparam int BIT   = CPB * 2 * HALFP;
    localparam int LAT   = 2 + CPB / 2 + 9 * CPB + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] b;
        longint     start_cyc;
        bit         timed;
    } exp_t;

    logic   clk;
    logic   nrst;
    longint cyc;
    int     n_vec;
    int     n_err;
    exp_t   exp_q[$];
    exp_t   mon_e;
    logic [7:0] last_good;
    logic [5:0] mon_cmds;
    logic [7:0] cmd_tab [6];

    t01_uart_cmd_rx_if bus ();

    t01_uart_cmd_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #HALFP clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign mon_cmds = {bus.cmd_start, bus.cmd_speed, bus.cmd_rot_l,
                       bus.cmd_rot_r, bus.cmd_right, bus.cmd_left};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Command table straight from the ASCII key map.
    function automatic logic [5:0] cmd_of(input logic [7:0] b);
        case (b)
            "a":     return 6'b000001;
            "d":     return 6'b000010;
            "w":     return 6'b000100;
            "q":     return 6'b001000;
            "s":     return 6'b010000;
            " ":     return 6'b100000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic expect_evt(input bit is_err, input logic [7:0] b, input bit timed);
        exp_t e;
        e.is_err    = is_err;
        e.b         = b;
        e.start_cyc = cyc;
        e.timed     = timed;
        exp_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_t);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            bus.rx = f[i];
            #(bit_t);
        end
    endtask

    task automatic idle(input int nbits);
        bus.rx = 1'b1;
        #(nbits * BIT);
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output event must match the head of the expected queue.
    always @(negedge clk) begin
        if (nrst) begin
            if (bus.rx_valid || bus.frame_err) begin
                chk("evt_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("evt_kind", {bus.frame_err, bus.rx_valid},
                        mon_e.is_err ? 2'b10 : 2'b01);
                    if (!mon_e.is_err) last_good = mon_e.b;
                    chk("rx_byte", bus.rx_byte, last_good);
                    chk("cmd", mon_cmds, mon_e.is_err ? 6'b0 : cmd_of(mon_e.b));
                    if (mon_e.timed && !mon_e.is_err)
                        chk("latency_window",
                            32'((cyc - mon_e.start_cyc) >= LAT - 1 &&
                                (cyc - mon_e.start_cyc) <= LAT + 1), 1);
                end
            end else if (mon_cmds != 6'b0) begin
                chk("stray_cmd", mon_cmds, 6'b0);
            end
        end
    end

    initial begin
        logic [9:0] f;
        int         scales [5];
        logic [7:0] b;
        int         gap;
        bit         bad;

        n_vec = 0;
        n_err = 0;
        last_good = 8'h00;
        cmd_tab = '{8'h61, 8'h64, 8'h77, 8'h71, 8'h73, 8'h20};
        scales  = '{970, 985, 1000, 1015, 1030};

        nrst   = 1'b0;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_byte", bus.rx_byte, 8'h00);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmds", mon_cmds, 0);
        nrst = 1'b1;
        realign();
        idle(2);

        // Single command byte with idle around it.
        expect_evt(0, 8'h61, 1);
        send_frame(8'h61, 1'b1, BIT);
        idle(2);
        chk("t1_busy", bus.busy, 0);
        chk("t1_pending", exp_q.size(), 0);

        // Back-to-back command bytes, no idle gap.
        foreach (cmd_tab[i]) begin
            if (i > 0) begin
                expect_evt(0, cmd_tab[i], 1);
                send_frame(cmd_tab[i], 1'b1, BIT);
            end
        end
        idle(2);
        chk("t2_pending", exp_q.size(), 0);

        // Uppercase: valid byte, no command.
        expect_evt(0, 8'h41, 1);
        send_frame(8'h41, 1'b1, BIT);
        idle(2);
        chk("t3_pending", exp_q.size(), 0);

        // Glitch shorter than half a bit.
        bus.rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.rx = 1'b1;
        idle(3);
        chk("t4_busy", bus.busy, 0);
        chk("t4_rx_byte", bus.rx_byte, 8'h41);

        // Framing error followed by a long break.
        expect_evt(1, 8'h55, 0);
        send_frame(8'h55, 1'b0, BIT);
        #(40 * BIT);
        chk("t5_busy_break", bus.busy, 1);
        idle(2);
        chk("t5_pending", exp_q.size(), 0);
        chk("t5_rx_byte_kept", bus.rx_byte, 8'h41);
        expect_evt(0, 8'h20, 1);
        send_frame(8'h20, 1'b1, BIT);
        idle(2);
        chk("t5b_pending", exp_q.size(), 0);

        // Reset in the middle of data bit 4 of 's'.
        f = {1'b1, 8'h73, 1'b0};
        for (int i = 0; i < 6; i++) begin
            bus.rx = f[i];
            #((i == 5) ? BIT / 2 : BIT);
        end
        nrst = 1'b0;
        #1;
        last_good = 8'h00;
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_rx_byte", bus.rx_byte, 8'h00);
        bus.rx = 1'b1;
        #(3 * HALFP);
        nrst = 1'b1;
        realign();
        idle(2);
        chk("t6_no_partial", exp_q.size(), 0);
        expect_evt(0, 8'h64, 1);
        send_frame(8'h64, 1'b1, BIT);
        idle(2);
        chk("t6_pending", exp_q.size(), 0);

        // Baud mismatch sweep, +/-3 %.
        foreach (scales[i]) begin
            expect_evt(0, 8'h61, 0);
            send_frame(8'h61, 1'b1, (BIT * scales[i]) / 1000);
            realign();
            idle(2);
        end
        chk("sweep_pending", exp_q.size(), 0);

        // Random frames: mix of command and arbitrary bytes, random gaps,
        // occasional framing error (always followed by idle so the line
        // returns high before the next start bit).
        for (int n = 0; n < 24; n++) begin
            b   = ($urandom_range(0, 1) != 0) ? cmd_tab[$urandom_range(0, 5)]
                                              : 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            gap = $urandom_range(0, 2);
            if (bad && gap == 0) gap = 1;
            expect_evt(bad, b, 1);
            send_frame(b, !bad, BIT);
            if (gap > 0) idle(gap);
        end
        idle(3);
        chk("rand_pending", exp_q.size(), 0);
        chk("end_busy", bus.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/t01_uart_cmd_rx.md
Name: t01_uart_cmd_rx

Overview:
- Serial 8N1 UART receiver for the Tetris FPGA build.
- Samples the asynchronous `rx` line, reassembles bytes LSB-first and flags framing errors.
- Decodes a fixed set of ASCII command bytes into single-cycle game-control pulses (left/right/rotate/speed/start).
- The top level ORs these pulses with the debounced push-button pulses before they enter t01_tetrisFSM, so a host PC terminal can drive the game.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per bit period (25 MHz / 115200 baud); legal range 4..4095.
- HALF_BIT, CLKS_PER_BIT/2, sample offset from the detected start edge to the middle of the start bit.

Ports:
- clk  input  1  system clock (clk_25m at top level)
- nrst  input  1  asynchronous active-low reset
- rx  input  1  raw serial line, idle high, asynchronous to clk
- rx_byte  output  8  last correctly framed byte
- rx_valid  output  1  one-cycle pulse, rx_byte just updated
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- busy  output  1  high whenever state != IDLE
- cmd_left  output  1  pulse on 0x61 ('a')
- cmd_right  output  1  pulse on 0x64 ('d')
- cmd_rot_r  output  1  pulse on 0x77 ('w')
- clk / nrst decided: one clock; reset is asynchronous and active-low.
- cmd_rot_l  output  1  pulse on 0x71 ('q')
- cmd_speed  output  1  pulse on 0x73 ('s')
- cmd_start  output  1  pulse on 0x20 (space)

Behaviour:
- Reset (nrst low, asynchronous):
  - State = IDLE; synchronizer flops = 1; bit counter, baud counter and shift register = 0.
  - rx_byte = 8'h00; all pulse outputs and busy = 0.
- Synchronizer: two flops on `rx`; all logic uses the second-stage value `rxs`. This adds 2 cycles of input latency.
- Baud counter: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). It is cleared on every state entry.
- IDLE:
  - rxs == 0 -> START.
- START:
  - When the counter reaches HALF_BIT-1, sample rxs.
  - rxs == 0 -> DATA with bit index = 0.
  - rxs == 1 -> false start (glitch); return to IDLE with no output pulse.
- DATA:
  - Each time the counter reaches CLKS_PER_BIT-1, shift rxs into bit[index]; LSB arrives first.
  - After index 7 is sampled -> STOP.
- STOP:
  - When the counter reaches CLKS_PER_BIT-1, sample rxs.
  - rxs == 1: on the next edge rx_byte <= shift register and rx_valid = 1 for exactly one cycle; the matching cmd_* pulse fires in the same cycle as rx_valid; -> IDLE.
  - rxs == 0: frame_err = 1 for one cycle, rx_byte unchanged, no cmd pulse; -> WAIT_HIGH.
- WAIT_HIGH (break / line fault): stay until rxs == 1, then -> IDLE. A held-low line therefore yields exactly one frame_err, not repeated frames.
- Command decode:
  - Exact 8-bit compare only; uppercase and all other bytes produce rx_valid with no cmd pulse.
  - At most one cmd_* is high in any cycle.
- Latency: rx_valid rises 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1) after the rx falling edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start bit immediately following a stop bit is captured without loss.
- Mid-frame reset: reset is asynchronous, so everything returns to reset values immediately. A partial byte is discarded and never emitted.

Test Plan:
1. CLKS_PER_BIT=16; send 0x61 at 16 clk/bit, idle between frames -> one rx_valid with rx_byte=0x61, one cmd_left pulse coincident with it, frame_err=0, busy low afterwards.
2. Send 0x64, 0x77, 0x71, 0x73, 0x20 back-to-back with no idle gap -> six rx_valid pulses in order (including test 1's byte), each with exactly the matching cmd pulse, no bytes lost.
3. Send 0x41 ('A') -> rx_valid with rx_byte=0x41, all cmd_* stay 0.
4. Drive rx low for 4 cycles, then high -> START returns to IDLE, no rx_valid, no frame_err.
5. Send 0x55 with stop bit forced low, then hold rx low for 40 bit times -> exactly one frame_err, rx_byte keeps its previous value, no rx_valid. Then release and send 0x20 -> valid frame with cmd_start.
6. Assert nrst low during data bit 4 of 0x73, release, then send 0x64 -> no output for 0x73; rx_byte=0x64 and cmd_right pulse. Sweep ±3% baud mismatch on 0x61 -> still decoded correctly.
